// File: rtl/video_sync_controller.sv
// BT.656 sync sequencer: tracks byte/line position from sync_parser H/V/F flags,
// qualifies frame geometry with a lock FSM and gates line/frame strobes on lock.
module video_sync_controller #(
   parameter int LINE_BYTES      = 1716,
   parameter int LINES_PER_FRAME = 525,
   parameter int LINE_TOL        = 4,
   parameter int LOCK_FRAMES     = 3,
   parameter int UNLOCK_FRAMES   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        H,
   input  logic        V,
   input  logic        F,
   output logic        line_start,
   output logic        frame_start,
   output logic [9:0]  line_idx,
   output logic [10:0] byte_idx,
   output logic        active,
   output logic        field,
   output logic        locked,
   output logic        lock_err
);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   // byte_idx saturates at 2047, so the watchdog needs its own wider counter
   localparam int               WD_W     = $clog2(2 * LINE_BYTES + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(2 * LINE_BYTES - 1);
   localparam logic [11:0]      LEN_MIN  = 12'(LINE_BYTES - LINE_TOL);
   localparam logic [11:0]      LEN_MAX  = 12'(LINE_BYTES + LINE_TOL);
   localparam logic [9:0]       LPF      = 10'(LINES_PER_FRAME);
   localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);
   localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_FRAMES);

   logic [1:0]      state_q, state_d;
   logic            h_prev_q, v_prev_q;
   logic [10:0]     byte_q, byte_d;
   logic [9:0]      line_q, line_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [3:0]      good_q, good_d, bad_q, bad_d;
   logic            line_bad_q, line_bad_d;
   logic            chk_en_q, chk_en_d;
   logic            line_start_q, line_start_d;
   logic            frame_start_q, frame_start_d;
   logic            active_q, active_d;
   logic            field_q, field_d;
   logic            lock_err_q, lock_err_d;

   logic        h_rise, h_fall, v_rise, is_locked;
   logic [11:0] line_len;
   logic        line_err, wd_fire, frame_good, frame_err;

   always_comb begin
      h_rise     = H & ~h_prev_q;
      h_fall     = ~H & h_prev_q;
      v_rise     = V & ~v_prev_q;
      is_locked  = (state_q == ST_LOCKED);
      line_len   = {1'b0, byte_q} + 12'd1;
      line_err   = h_rise & chk_en_q & ((line_len < LEN_MIN) | (line_len > LEN_MAX));
      wd_fire    = ~h_rise & (wd_q == WD_LAST);
      // a line completing on the V_rise cycle still belongs to the frame being judged
      frame_good = (line_q == LPF) & ~line_bad_q & ~line_err;

      byte_d = h_rise ? '0 : ((byte_q == '1) ? byte_q : byte_q + 11'd1);
      wd_d   = h_rise ? '0 : ((wd_q == '1) ? wd_q : wd_q + 1'b1);
      line_d = v_rise ? '0 : (h_rise ? ((line_q == '1) ? line_q : line_q + 10'd1) : line_q);

      state_d       = state_q;
      good_d        = good_q;
      bad_d         = bad_q;
      chk_en_d      = chk_en_q | h_rise;
      line_bad_d    = v_rise ? 1'b0 : (line_bad_q | line_err);
      frame_start_d = 1'b0;
      frame_err     = 1'b0;

      if (v_rise) begin
         case (state_q)
            ST_SEARCH: begin
               state_d = ST_ACQUIRE;
               good_d  = '0;
            end
            ST_ACQUIRE: begin
               if (frame_good) begin
                  if (good_q + 4'd1 == LOCK_N) begin
                     state_d       = ST_LOCKED;
                     good_d        = '0;
                     bad_d         = '0;
                     frame_start_d = 1'b1;
                  end else begin
                     good_d = good_q + 4'd1;
                  end
               end else begin
                  good_d    = '0;
                  frame_err = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (frame_good) begin
                  bad_d         = '0;
                  frame_start_d = 1'b1;
               end else begin
                  frame_err = 1'b1;
                  if (bad_q + 4'd1 == UNLOCK_N) begin
                     state_d  = ST_SEARCH;
                     good_d   = '0;
                     bad_d    = '0;
                     chk_en_d = 1'b0;
                  end else begin
                     bad_d         = bad_q + 4'd1;
                     frame_start_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end

      if (wd_fire) begin
         state_d       = ST_SEARCH;
         good_d        = '0;
         bad_d         = '0;
         chk_en_d      = 1'b0;
         line_bad_d    = 1'b0;
         frame_start_d = 1'b0;
      end

      lock_err_d   = line_err | frame_err | wd_fire;
      line_start_d = h_fall & is_locked & ~V;
      active_d     = is_locked & ~H & ~V;
      field_d      = v_rise ? F : field_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_SEARCH;
         h_prev_q      <= 1'b0;
         v_prev_q      <= 1'b0;
         byte_q        <= '0;
         line_q        <= '0;
         wd_q          <= '0;
         good_q        <= '0;
         bad_q         <= '0;
         line_bad_q    <= 1'b0;
         chk_en_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         active_q      <= 1'b0;
         field_q       <= 1'b0;
         lock_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_prev_q      <= H;
         v_prev_q      <= V;
         byte_q        <= byte_d;
         line_q        <= line_d;
         wd_q          <= wd_d;
         good_q        <= good_d;
         bad_q         <= bad_d;
         line_bad_q    <= line_bad_d;
         chk_en_q      <= chk_en_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         active_q      <= active_d;
         field_q       <= field_d;
         lock_err_q    <= lock_err_d;
      end
   end

   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign line_idx    = line_q;
   assign byte_idx    = byte_q;
   assign active      = active_q;
   assign field       = field_q;
   assign locked      = (state_q == ST_LOCKED);
   assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_video_sync_controller.sv
// Directed bench for video_sync_controller: generates scaled BT.656 frames and
// scoreboards the full output vector one byte behind the stimulus.
module tb_video_sync_controller;

   localparam int LB  = 40;
   localparam int LPF = 6;
   localparam int TOL = 4;
   localparam int HB  = 8;

   logic        clk = 1'b0;
   logic        reset, H, V, F;
   logic        line_start, frame_start, active, field, locked, lock_err;
   logic [9:0]  line_idx;
   logic [10:0] byte_idx;

   video_sync_controller #(
      .LINE_BYTES      (LB),
      .LINES_PER_FRAME (LPF),
      .LINE_TOL        (TOL),
      .LOCK_FRAMES     (3),
      .UNLOCK_FRAMES   (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .H           (H),
      .V           (V),
      .F           (F),
      .line_start  (line_start),
      .frame_start (frame_start),
      .line_idx    (line_idx),
      .byte_idx    (byte_idx),
      .active      (active),
      .field       (field),
      .locked      (locked),
      .lock_err    (lock_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [26:0] val;
      int          fr;
      int          ln;
      int          by;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   bit   exp_locked;
   bit   exp_field;
   int   pre_v;
   int   fr_no;

   // {locked, active, line_start, frame_start, lock_err, field, line_idx, byte_idx}
   function automatic logic [26:0] obs_vec();
      return {locked, active, line_start, frame_start, lock_err, field, line_idx, byte_idx};
   endfunction

   task automatic cmp(input string tag, input int fr, input int ln, input int by,
                      input logic [26:0] expv);
      logic [26:0] o;
      o = obs_vec();
      n_cmp++;
      assert (o === expv) else begin
         n_mis++;
         $error("FAIL %s fr=%0d ln=%0d by=%0d got=%h exp=%h", tag, fr, ln, by, o, expv);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp("stream", e.fr, e.ln, e.by, e.val);
      end
   endtask

   task automatic drive_byte(input bit h, input bit v, input bit f, input exp_t e);
      @(negedge clk);
      pop_check();
      H = h;
      V = v;
      F = f;
      sb.push_back(e);
   endtask

   // One frame; V rises at byte voff of line 0 and judges the previous frame.
   task automatic emit_frame(input int nl, input int voff, input int badk, input int badlen,
                             input bit bad_err, input bit fs_e, input bit ferr_e, input bit lock_e);
      int   len, li;
      bit   h, v, f, ls, act, fs, err, pend;
      exp_t e;
      pend = 1'b0;
      fr_no++;
      for (int k = 0; k < nl; k++) begin
         len = (k == badk) ? badlen : LB;
         for (int b = 0; b < len; b++) begin
            h   = (b < HB);
            v   = (k == 0) ? (b >= voff) : (k == 1) ? 1'b1 : (k == 2) ? (b < voff) : 1'b0;
            f   = fr_no[0] ^ (k >= nl / 2);
            ls  = (b == HB) && exp_locked && !v;
            act = exp_locked && !h && !v;
            li  = (k == 0 && b < voff) ? pre_v : k;
            fs  = 1'b0;
            err = 1'b0;
            if (k == 0 && b == voff) begin
               fs         = fs_e;
               err        = ferr_e;
               exp_locked = lock_e;
               exp_field  = f;
            end
            if (b == 0 && pend) begin
               err  = 1'b1;
               pend = 1'b0;
            end
            if (len > 2 * LB && b == 2 * LB) begin
               err        = 1'b1;
               exp_locked = 1'b0;
            end
            e.val = {exp_locked, act, ls, fs, err, exp_field, 10'(li), 11'(b)};
            e.fr  = fr_no;
            e.ln  = k;
            e.by  = b;
            drive_byte(h, v, f, e);
         end
         if (k == badk && bad_err) pend = 1'b1;
      end
      pre_v = nl;
   endtask

   task automatic restart_stream();
      exp_locked = 1'b0;
      exp_field  = 1'b0;
      pre_v      = 1;
      fr_no      = 0;
   endtask

   initial begin
      reset = 1'b1;
      H = 1'b0;
      V = 1'b0;
      F = 1'b0;
      restart_stream();
      repeat (2) @(negedge clk);
      cmp("reset_init", 0, 0, 0, '0);
      @(negedge clk);
      reset = 1'b0;

      // acquisition: SEARCH->ACQUIRE on V_rise 1, locked on V_rise 4
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 4; i <= 10; i++)
         emit_frame(LPF, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);

      // short frames: single bad frame tolerated, two in a row unlock
      emit_frame(LPF - 1, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      emit_frame(LPF,     3, -1, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      emit_frame(LPF - 1, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      emit_frame(LPF - 1, 3, -1, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      emit_frame(LPF,     3, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);

      // reacquire, then line-length tolerance edge and violation
      emit_frame(LPF, 3, -1, 0,            1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0,            1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0,            1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3,  2, LB - TOL,     1'b0, 1'b1, 1'b0, 1'b1);
      emit_frame(LPF, 3,  2, LB - TOL - 6, 1'b1, 1'b1, 1'b0, 1'b1);
      emit_frame(LPF, 3, -1, 0,            1'b0, 1'b1, 1'b1, 1'b1);

      // 7 lines so the coincident H/V rise sees a pre-clear count of LPF
      emit_frame(LPF + 1, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      emit_frame(LPF,     0, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);

      // stalled H trips the watchdog, then reacquire
      emit_frame(LPF, 3,  2, 2 * LB + 20, 1'b0, 1'b1, 1'b0, 1'b1);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      emit_frame(3,   3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);

      // asynchronous reset while locked
      @(negedge clk);
      pop_check();
      reset = 1'b1;
      H = 1'b0;
      V = 1'b0;
      F = 1'b0;
      #1;
      cmp("reset_async", fr_no, 0, 0, '0);
      repeat (3) begin
         @(negedge clk);
         cmp("reset_hold", fr_no, 0, 0, '0);
      end
      reset = 1'b0;
      restart_stream();

      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      emit_frame(LPF, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1);

      @(negedge clk);
      pop_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/video_sync_controller.md
Name: video_sync_controller

Overview:
- Sequences the descrambler/scrambler datapath from the H/V/F flags produced by sync_parser, one BT.656 byte per clk.
- Tracks line and byte position and runs a lock FSM that qualifies frame geometry.
- Issues per-line and per-frame start pulses plus an active-video window only while locked, so downstream line buffers never act on a broken stream.

Parameters:
- LINE_BYTES, 1716, nominal bytes per line (2 x 858 samples).
- LINES_PER_FRAME, 525, required H rising edges between consecutive V rising edges.
- LINE_TOL, 4, allowed ± deviation of a measured line length in bytes.
- LOCK_FRAMES, 3, consecutive good frames required to enter LOCKED.
- UNLOCK_FRAMES, 2, consecutive bad frames in LOCKED that force SEARCH.

Ports:
- clk  in  1  byte clock, same domain as sync_parser.
- reset  in  1  asynchronous, active-high reset.
- H  in  1  horizontal blanking flag from sync_parser.
- V  in  1  vertical blanking flag from sync_parser.
- F  in  1  field flag from sync_parser.
- line_start  out  1  one-cycle pulse at start of active video of each line; only in LOCKED.
- frame_start  out  1  one-cycle pulse on V rising; only in LOCKED.
- line_idx  out  10  lines since last V rising, saturates at 1023.
- byte_idx  out  11  bytes since last H rising, saturates at 2047.
- active  out  1  high while locked, H=0 and V=0.
- field  out  1  F registered at last V rising.
- locked  out  1  high in LOCKED state.
- lock_err  out  1  one-cycle pulse whenever a frame or line check fails, in any state.

Behaviour:
- Reset (async, reset=1): every output 0, counters 0, H/V/F history registers 0, FSM = SEARCH, good/bad counters 0.
- Edge detect: H_prev/V_prev are registered. H_rise = H & ~H_prev. H_fall = ~H & H_prev. V_rise = V & ~V_prev. All outputs are registered, giving 1-cycle latency from the input sample.
- byte_idx: cleared to 0 on H_rise, otherwise +1, saturating.
- Line length check: on H_rise, the completed length (byte_idx+1) must lie in LINE_BYTES±LINE_TOL. A violation sets the frame's line_bad flag and pulses lock_err. The first H_rise after reset or after SEARCH entry is not checked.
- line_idx: +1 on H_rise (saturating); cleared on V_rise. If H_rise and V_rise occur in the same cycle, V_rise wins: line_idx=0, byte_idx=0.
- Frame check on V_rise: good = (line_idx == LINES_PER_FRAME) and not line_bad. line_bad is then cleared.
- Watchdog: if byte_idx reaches 2*LINE_BYTES with no H_rise, go to SEARCH, clear good/bad counters, pulse lock_err once.
- FSM:
  - SEARCH: wait for V_rise, then go to ACQUIRE with good_cnt=0. The partial frame is not judged.
  - ACQUIRE: on each V_rise, a good frame increments good_cnt; a bad frame clears good_cnt and pulses lock_err. When good_cnt reaches LOCK_FRAMES, go to LOCKED. frame_start fires on this same V_rise.
  - LOCKED: a good frame clears bad_cnt. A bad frame increments bad_cnt and pulses lock_err. When bad_cnt reaches UNLOCK_FRAMES, go to SEARCH. The frame_start for that V_rise is suppressed.
- line_start: pulses on H_fall when locked=1 and V=0.
- field: updated on every V_rise regardless of state.
- F toggling mid-frame has no effect on lock.
- Reset asserted mid-frame: outputs drop to 0 immediately (asynchronous); reacquisition starts from SEARCH.

Test Plan:
- Reset mid-stream (reset=1 for 3 cycles while locked) -> all outputs 0 within the same cycle; after release, locked stays 0 until 3 good frames after the first V_rise, i.e. locked at the 4th V_rise.
- 10 ideal frames (1716 bytes/line, 525 lines, H/V as from sync_parser) -> locked rises 1 cycle after the 4th V_rise; 7 frame_start pulses; 525 line_idx increments per frame; line_start count = number of lines with V=0; lock_err never pulses.
- While locked, one frame with 524 lines -> one lock_err pulse, locked stays 1. Two consecutive such frames -> locked=0 after the 2nd V_rise, frame_start suppressed on that V_rise.
- One line of 1712 bytes (within tolerance) -> no error. One line of 1700 bytes -> lock_err on its H_rise; that frame is counted bad.
- H held low for 3432 bytes -> watchdog fires: lock_err pulse, FSM=SEARCH, locked=0, then reacquisition per the ideal-frame scenario.
- H_rise and V_rise in the same cycle -> line_idx=0 and byte_idx=0 next cycle; the frame is judged on the pre-clear line count.
